sky_fetch_stage: RTL

SKY_FETCH_STAGE -- requirements
Module: sky_fetch_stage

---
 rtl/sky_fetch_stage_if.sv | 25 ++
 rtl/sky_fetch_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sky_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface sky_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/sky_fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, PC tag queue,
// response buffer feeding registered decode outputs, redirect flush/discard.
module sky_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  sky_fetch_stage_if.master imem,
  output logic [31:0]       pc_out,
  output logic [31:0]       instruction,
  output logic              inst_valid
);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [PW-1:0] buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic [31:0]   inst_q, inst_d;
  logic          vld_q, vld_d;

  logic [31:0]   buf_pc_q   [BUF_DEPTH];
  logic [31:0]   buf_inst_q [BUF_DEPTH];
  logic [31:0]   tag_pc_q   [BUF_DEPTH];

  logic [CW-1:0] occupancy;
  logic          accept, rsp_live, rsp_keep;
  logic          buf_we, tag_we, pop, bypass;

  // Outstanding plus buffered never exceeds the buffer, so every response has a slot.
  assign occupancy           = in_flight_q + buf_cnt_q;
  assign imem.imem_req_valid = reset_n && !redirect_valid && (occupancy < DEPTH_C);
  assign imem.imem_addr      = fetch_pc_q;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_live            = imem.imem_rsp_valid && (in_flight_q != '0);
  assign rsp_keep            = rsp_live && (discard_q == '0);

  assign pc_out      = pc_out_q;
  assign instruction = inst_q;
  assign inst_valid  = vld_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    in_flight_d = in_flight_q;
    discard_d   = discard_q;
    buf_cnt_d   = buf_cnt_q;
    buf_wp_d    = buf_wp_q;
    buf_rp_d    = buf_rp_q;
    tag_wp_d    = tag_wp_q;
    tag_rp_d    = tag_rp_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    vld_d       = vld_q;
    buf_we      = 1'b0;
    tag_we      = 1'b0;
    pop         = 1'b0;
    bypass      = 1'b0;

    if (redirect_valid) begin
      fetch_pc_d  = redirect_pc;
      buf_cnt_d   = '0;
      buf_wp_d    = '0;
      buf_rp_d    = '0;
      tag_wp_d    = '0;
      tag_rp_d    = '0;
      inst_d      = '0;
      vld_d       = 1'b0;
      // Everything still outstanding after this cycle belongs to the old path.
      in_flight_d = in_flight_q - CW'(rsp_live);
      discard_d   = in_flight_d;
    end else begin
      if (accept) begin
        tag_we     = 1'b1;
        tag_wp_d   = tag_wp_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_keep) begin
        tag_rp_d = tag_rp_q + PW'(1);
      end else if (rsp_live) begin
        discard_d = discard_q - CW'(1);
      end
      in_flight_d = in_flight_q + CW'(accept) - CW'(rsp_live);

      if (!stall) begin
        if (buf_cnt_q != '0) begin
          pc_out_d = buf_pc_q[buf_rp_q];
          inst_d   = buf_inst_q[buf_rp_q];
          vld_d    = 1'b1;
          pop      = 1'b1;
          buf_rp_d = buf_rp_q + PW'(1);
        end else if (rsp_keep) begin
          pc_out_d = tag_pc_q[tag_rp_q];
          inst_d   = imem.imem_rsp_data;
          vld_d    = 1'b1;
          bypass   = 1'b1;
        end else begin
          inst_d = '0;
          vld_d  = 1'b0;
        end
      end

      if (rsp_keep && !bypass) begin
        buf_we   = 1'b1;
        buf_wp_d = buf_wp_q + PW'(1);
      end
      buf_cnt_d = buf_cnt_q + CW'(buf_we) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
      buf_cnt_q   <= '0;
      buf_wp_q    <= '0;
      buf_rp_q    <= '0;
      tag_wp_q    <= '0;
      tag_rp_q    <= '0;
      pc_out_q    <= '0;
      inst_q      <= '0;
      vld_q       <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
      buf_cnt_q   <= buf_cnt_d;
      buf_wp_q    <= buf_wp_d;
      buf_rp_q    <= buf_rp_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      pc_out_q    <= pc_out_d;
      inst_q      <= inst_d;
      vld_q       <= vld_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters and pointers.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_pc_q[buf_wp_q]   <= tag_pc_q[tag_rp_q];
      buf_inst_q[buf_wp_q] <= imem.imem_rsp_data;
    end
    if (tag_we) begin
      tag_pc_q[tag_wp_q] <= fetch_pc_q;
    end
  end
endmodule
